// File: rtl/mpcu_datapath_pkg.sv
// Shared state-code definitions for the microprogram control unit and its datapath.
package mpcu_datapath_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    Y0 = 4'd0,
    Y1 = 4'd1,
    Y2 = 4'd2,
    Y3 = 4'd3,
    Y4 = 4'd4,
    Y5 = 4'd5,
    Y6 = 4'd6,
    Y7 = 4'd7,
    Y8 = 4'd8,
    YK = 4'd9
  } state_e;

  function automatic logic is_legal_code(input logic [STATE_W-1:0] code);
    return code <= YK;
  endfunction

endpackage

// File: rtl/mpcu_datapath_if.sv
// Control-code, operand and status bundle between control unit / bench and the datapath.
interface mpcu_datapath_if #(
  parameter int unsigned WIDTH = 8
);
  import mpcu_datapath_pkg::*;

  logic [STATE_W-1:0] i_state;
  logic [WIDTH-1:0]   i_a;
  logic [WIDTH-1:0]   i_b;
  logic               o_x1;
  logic               o_x2;
  logic [2*WIDTH-1:0] o_result;
  logic               o_valid;
  logic               o_err;

  modport master (
    output i_state, i_a, i_b,
    input  o_x1, o_x2, o_result, o_valid, o_err
  );

  modport slave (
    input  i_state, i_a, i_b,
    output o_x1, o_x2, o_result, o_valid, o_err
  );

endinterface

// File: rtl/mpcu_datapath.sv
// Shift-free multiplier datapath: executes the micro-operation selected by the control
// code each cycle and computes A*B by repeated addition.
module mpcu_datapath
  import mpcu_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mpcu_datapath_if.slave bus
);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    // valid is a one-cycle pulse: only the edge ending Y8 sets it
    valid_d  = 1'b0;
    case (bus.i_state)
      Y0: begin
        a_d   = bus.i_a;
        b_d   = bus.i_b;
        cnt_d = '0;
        acc_d = '0;
        err_d = 1'b0;
      end
      Y2: acc_d = '0;
      Y4: begin
        acc_d = acc_q + {{WIDTH{1'b0}}, a_q};
        cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
      Y6: result_d = acc_q;
      Y7: result_d = '0;
      Y8: valid_d  = 1'b1;
      default: begin
        if (!is_legal_code(bus.i_state)) err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_x1     = (b_q != '0);
  assign bus.o_x2     = (cnt_q == b_q);
  assign bus.o_result = result_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_err    = err_q;

endmodule

// File: tb/tb_mpcu_datapath.sv
// Bench for mpcu_datapath: a behavioural control unit drives state codes, a product-level
// model predicts the outputs every cycle, and directed literals pin key results.
module tb_mpcu_datapath;

  localparam int unsigned W = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  mpcu_datapath_if #(.WIDTH(W)) bus ();

  mpcu_datapath #(.WIDTH(W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks operands, Y4 count since Y0 and additions since the last clear,
  // and derives the product with plain multiplication.
  logic [W-1:0]   m_a, m_b;
  int unsigned    m_loops, m_adds;
  logic [2*W-1:0] m_res;
  logic           m_valid, m_err;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_a <= '0; m_b <= '0; m_loops <= 0; m_adds <= 0;
      m_res <= '0; m_valid <= 1'b0; m_err <= 1'b0;
    end else begin
      m_valid <= (bus.i_state == 4'd8);
      case (bus.i_state)
        4'd0: begin
          m_a <= bus.i_a; m_b <= bus.i_b; m_loops <= 0; m_adds <= 0; m_err <= 1'b0;
        end
        4'd2: m_adds <= 0;
        4'd4: begin m_loops <= m_loops + 1; m_adds <= m_adds + 1; end
        4'd6: m_res <= 16'(m_a * m_adds);
        4'd7: m_res <= '0;
        4'd1, 4'd3, 4'd5, 4'd8, 4'd9: ;
        default: m_err <= 1'b1;
      endcase
    end
  end

  always @(negedge i_clk) begin
    check("x1",     {31'd0, bus.o_x1},    {31'd0, m_b != '0});
    check("x2",     {31'd0, bus.o_x2},    {31'd0, m_loops[W-1:0] == m_b});
    check("result", {16'd0, bus.o_result}, {16'd0, m_res});
    check("valid",  {31'd0, bus.o_valid}, {31'd0, m_valid});
    check("err",    {31'd0, bus.o_err},   {31'd0, m_err});
  end

  task automatic drive(input logic [3:0] s);
    bus.i_state = s;
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Behavioural control unit: branches on x1 in Y1 and x2 in Y5.
  task automatic run_cu(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int latency, output int iters, output logic x1_seen,
                        output logic [2:0] x2_first);
    logic lx2;
    latency = 0; iters = 0; x2_first = '0;
    bus.i_a = a; bus.i_b = b;
    drive(4'd0); tick; latency++;
    bus.i_a = ~a; bus.i_b = ~b;
    drive(4'd1); x1_seen = bus.o_x1; tick; latency++;
    if (x1_seen) begin
      do begin
        drive(4'd4); tick; latency++;
        drive(4'd5); lx2 = bus.o_x2;
        if (iters < 3) x2_first[iters] = lx2;
        tick; latency++; iters++;
      end while (!lx2 && iters < 300);
      if (!lx2) check("loop_bound", 32'(iters), 32'(b));
      drive(4'd6); tick; latency++;
    end else begin
      drive(4'd2); tick; latency++;
      drive(4'd3); tick; latency++;
      drive(4'd7); tick; latency++;
    end
    drive(4'd8); check("valid_before_yk", {31'd0, bus.o_valid}, 32'd0); tick; latency++;
    drive(4'd9); check("valid_in_yk", {31'd0, bus.o_valid}, 32'd1); tick;
    check("valid_after_yk", {31'd0, bus.o_valid}, 32'd0);
    drive(4'd3);
  endtask

  int lat, it;
  logic x1s;
  logic [2:0] x2f;

  initial begin
    bus.i_state = 4'd3; bus.i_a = '0; bus.i_b = '0;
    #12;
    check("rst_result", {16'd0, bus.o_result}, 32'd0);
    check("rst_x1", {31'd0, bus.o_x1}, 32'd0);
    check("rst_x2", {31'd0, bus.o_x2}, 32'd1);
    i_rst = 1'b0;
    tick;

    run_cu(8'd5, 8'd3, lat, it, x1s, x2f);
    check("5x3_x1", {31'd0, x1s}, 32'd1);
    check("5x3_x2seq", {29'd0, x2f}, 32'b100);
    check("5x3_result", {16'd0, bus.o_result}, 32'd15);
    check("5x3_latency", 32'(lat), 32'd10);

    run_cu(8'd7, 8'd0, lat, it, x1s, x2f);
    check("7x0_x1", {31'd0, x1s}, 32'd0);
    check("7x0_result", {16'd0, bus.o_result}, 32'd0);
    check("7x0_latency", 32'(lat), 32'd6);

    run_cu(8'd255, 8'd255, lat, it, x1s, x2f);
    check("255sq_result", {16'd0, bus.o_result}, 32'hFE01);
    check("255sq_latency", 32'(lat), 32'd514);

    drive(4'd12); tick;
    check("illegal_err", {31'd0, bus.o_err}, 32'd1);
    check("illegal_result_hold", {16'd0, bus.o_result}, 32'hFE01);
    check("illegal_b_hold", {31'd0, bus.o_x1}, 32'd1);
    drive(4'd3); tick;
    check("err_sticky", {31'd0, bus.o_err}, 32'd1);
    bus.i_a = 8'd1; bus.i_b = 8'd1;
    drive(4'd0); tick;
    check("y0_clears_err", {31'd0, bus.o_err}, 32'd0);
    check("y0_keeps_result", {16'd0, bus.o_result}, 32'hFE01);

    // Interrupted run: set err, enter the loop, reset asynchronously mid Y4
    bus.i_a = 8'd9; bus.i_b = 8'd6;
    drive(4'd0); tick;
    drive(4'd1); tick;
    drive(4'd11); tick;
    drive(4'd4); tick;
    drive(4'd5); tick;
    drive(4'd4);
    #1 i_rst = 1'b1;
    #1;
    check("async_rst_result", {16'd0, bus.o_result}, 32'd0);
    check("async_rst_err", {31'd0, bus.o_err}, 32'd0);
    check("async_rst_x1", {31'd0, bus.o_x1}, 32'd0);
    check("async_rst_x2", {31'd0, bus.o_x2}, 32'd1);
    check("async_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    drive(4'd3);
    @(negedge i_clk); #2 i_rst = 1'b0;
    tick;
    run_cu(8'd9, 8'd6, lat, it, x1s, x2f);
    check("9x6_result", {16'd0, bus.o_result}, 32'd54);
    check("9x6_iters", 32'(it), 32'd6);

    run_cu(8'd0, 8'd4, lat, it, x1s, x2f);
    check("0x4_iters", 32'(it), 32'd4);
    check("0x4_result", {16'd0, bus.o_result}, 32'd0);
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
